// File: rtl/uc_pila_fsm_if.sv
// Control bus between the stack-machine sequencer and its datapath.
// The sequencer drives the strobes and the datapath supplies opcode and z.
interface uc_pila_fsm_if #(
  parameter int OPW   = 6,
  parameter int ALUW  = 3,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [OPW-1:0]  opcode;
  logic            z;
  logic            pc_en;
  logic            s_inc;
  logic            s_ret;
  logic            s_inm;
  logic            s_pila;
  logic            we3;
  logic            wez;
  logic            push;
  logic            pop;
  logic [ALUW-1:0] op_alu;
  logic [SPW-1:0]  sp_level;
  logic            halted;
  logic            fault;

  modport master (
    input  opcode, z,
    output pc_en, s_inc, s_ret, s_inm, s_pila, we3, wez, push, pop,
           op_alu, sp_level, halted, fault
  );

  modport slave (
    output opcode, z,
    input  pc_en, s_inc, s_ret, s_inm, s_pila, we3, wez, push, pop,
           op_alu, sp_level, halted, fault
  );
endinterface

// File: rtl/uc_pila_fsm.sv
// Instruction sequencer for a small stack CPU: single-cycle decode plus a
// second cycle for stack operations, with stack-depth tracking and sticky halt/fault.
//
//   state | meaning
//   EXEC  | decode live opcode, one-cycle instructions complete here
//   STK   | second cycle of push/pop/call/ret, decoded from latched opcode
//   HALT  | 111111 executed, all enables off until reset
//   FAULT | stack overflow/underflow, all enables off, sp_level frozen
module uc_pila_fsm #(
  parameter int OPW   = 6,
  parameter int ALUW  = 3,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  uc_pila_fsm_if.master      bus
);
  localparam int SPW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EXEC, STK, HALT, FAULT} state_t;

  state_t          state_q, state_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [1:0]      stk_op_q;
  logic [5:0]      op6;
  logic            full, empty;

  logic            pc_en_c, s_inc_c, s_ret_c, s_inm_c, s_pila_c;
  logic            we3_c, wez_c, push_c, pop_c;
  logic [ALUW-1:0] op_alu_c;

  assign op6   = bus.opcode[OPW-1 -: 6];
  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EXEC;
      sp_q     <= '0;
      stk_op_q <= 2'b00;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      // low two opcode bits distinguish push/pop/call/ret in STK
      if (state_q == EXEC && state_d == STK)
        stk_op_q <= op6[1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    pc_en_c  = 1'b0;
    s_inc_c  = 1'b1;
    s_ret_c  = 1'b0;
    s_inm_c  = 1'b0;
    s_pila_c = 1'b0;
    we3_c    = 1'b0;
    wez_c    = 1'b0;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    op_alu_c = '0;

    case (state_q)
      EXEC: begin
        if (!op6[5]) begin
          op_alu_c = op6[4 -: ALUW];
          we3_c    = 1'b1;
          wez_c    = 1'b1;
          pc_en_c  = 1'b1;
        end else begin
          case (op6)
            6'b100000: begin
              s_inm_c = 1'b1;
              we3_c   = 1'b1;
              pc_en_c = 1'b1;
            end
            6'b100001: begin
              s_inc_c = 1'b0;
              pc_en_c = 1'b1;
            end
            6'b100010: begin
              pc_en_c = 1'b1;
              s_inc_c = ~bus.z;
            end
            6'b100011: begin
              pc_en_c = 1'b1;
              s_inc_c = bus.z;
            end
            6'b100100, 6'b100110: begin
              if (!full) begin
                push_c  = 1'b1;
                sp_d    = sp_q + SPW'(1);
                state_d = STK;
              end else begin
                state_d = FAULT;
              end
            end
            6'b100101, 6'b100111: begin
              if (!empty) begin
                pop_c   = 1'b1;
                sp_d    = sp_q - SPW'(1);
                state_d = STK;
              end else begin
                state_d = FAULT;
              end
            end
            6'b111111: state_d = HALT;
            default:   pc_en_c = 1'b1;
          endcase
        end
      end
      STK: begin
        pc_en_c = 1'b1;
        case (stk_op_q)
          2'b00: ;
          2'b01: begin
            s_pila_c = 1'b1;
            we3_c    = 1'b1;
          end
          2'b10: s_inc_c = 1'b0;
          default: s_ret_c = 1'b1;
        endcase
        state_d = EXEC;
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = EXEC;
    endcase
  end

  // write/load strobes are forced low for as long as reset is held
  assign bus.pc_en    = pc_en_c & reset;
  assign bus.we3      = we3_c   & reset;
  assign bus.wez      = wez_c   & reset;
  assign bus.push     = push_c  & reset;
  assign bus.pop      = pop_c   & reset;
  assign bus.s_inc    = s_inc_c;
  assign bus.s_ret    = s_ret_c;
  assign bus.s_inm    = s_inm_c;
  assign bus.s_pila   = s_pila_c;
  assign bus.op_alu   = op_alu_c;
  assign bus.sp_level = sp_q;
  assign bus.halted   = (state_q == HALT);
  assign bus.fault    = (state_q == FAULT);
endmodule
